// File: rtl/omux_sync.sv
// Run-time output select for the LUT/FF cell pair. A select change goes through
// a ready/valid handshake and a fixed hold window, so the output never glitches.
module omux_sync #(
  parameter int WIDTH           = 1,
  parameter int NUM_INPUTS      = 2,
  parameter int DEFAULT_SEL     = 0,
  parameter int HOLD_CYCLES     = 1,
  parameter int REGISTER_OUTPUT = 1,
  localparam int SELW           = (NUM_INPUTS > 2) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_INPUTS*WIDTH-1:0] in,
  input  logic [SELW-1:0]             sel_req,
  input  logic                        sel_valid,
  output logic                        sel_ready,
  output logic [SELW-1:0]             cur_sel,
  output logic [WIDTH-1:0]            out,
  output logic                        switching,
  output logic                        sel_err
);

  localparam int CNTW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [CNTW-1:0] HOLD_CNT = CNTW'(HOLD_CYCLES);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
  localparam logic [SELW-1:0] DEF_SEL  = SELW'(DEFAULT_SEL);
  localparam logic [SELW:0]   NUM_W    = (SELW + 1)'(NUM_INPUTS);

  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("omux_sync: HOLD_CYCLES must be at least 1");
  end
  if (NUM_INPUTS < 2) begin : g_bad_num
    $error("omux_sync: NUM_INPUTS must be at least 2");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("omux_sync: WIDTH must be at least 1");
  end
  if (DEFAULT_SEL >= NUM_INPUTS || DEFAULT_SEL < 0) begin : g_bad_def
    $error("omux_sync: DEFAULT_SEL out of range");
  end

  typedef enum logic {
    ACTIVE = 1'b0,
    HOLD   = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [SELW-1:0]  cur_sel_reg, cur_sel_next;
  logic [SELW-1:0]  pending_reg, pending_next;
  logic [CNTW-1:0]  cnt_reg, cnt_next;
  logic [WIDTH-1:0] hold_reg, hold_next;
  logic             sel_err_reg, sel_err_next;

  logic [WIDTH-1:0] chan [NUM_INPUTS];
  logic [WIDTH-1:0] cur_data;
  logic             accept;
  logic             req_in_range;

  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_chan
    assign chan[gi] = in[gi*WIDTH +: WIDTH];
  end

  assign cur_data     = chan[cur_sel_reg];
  assign sel_ready    = (state_reg == ACTIVE) && !rst;
  assign accept       = sel_valid && sel_ready;
  assign req_in_range = {1'b0, sel_req} < NUM_W;

  always_comb begin
    state_next   = state_reg;
    cur_sel_next = cur_sel_reg;
    pending_next = pending_reg;
    cnt_next     = cnt_reg;
    hold_next    = hold_reg;
    sel_err_next = 1'b0;
    case (state_reg)
      ACTIVE: begin
        hold_next = cur_data;
        if (accept) begin
          if (!req_in_range) begin
            sel_err_next = 1'b1;
          end else if (sel_req != cur_sel_reg) begin
            pending_next = sel_req;
            cnt_next     = HOLD_CNT;
            state_next   = HOLD;
          end
        end
      end
      HOLD: begin
        // Requests arriving here are ignored, not queued.
        if (cnt_reg == CNT_ONE) begin
          cur_sel_next = pending_reg;
          state_next   = ACTIVE;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ACTIVE;
      cur_sel_reg <= DEF_SEL;
      pending_reg <= DEF_SEL;
      cnt_reg     <= '0;
      hold_reg    <= '0;
      sel_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cur_sel_reg <= cur_sel_next;
      pending_reg <= pending_next;
      cnt_reg     <= cnt_next;
      hold_reg    <= hold_next;
      sel_err_reg <= sel_err_next;
    end
  end

  if (REGISTER_OUTPUT != 0) begin : g_reg_out
    logic [WIDTH-1:0] out_reg;
    // In HOLD the register simply re-loads the frozen value.
    always_ff @(posedge clk) begin
      if (rst) begin
        out_reg <= '0;
      end else begin
        out_reg <= (state_reg == ACTIVE) ? cur_data : hold_reg;
      end
    end
    assign out = out_reg;
  end else begin : g_comb_out
    assign out = (state_reg == ACTIVE) ? cur_data : hold_reg;
  end

  assign cur_sel   = cur_sel_reg;
  assign switching = (state_reg == HOLD);
  assign sel_err   = sel_err_reg;

endmodule

// File: tb/tb_omux_sync.sv
// Bench for omux_sync: two configurations (registered/combinational output)
// driven by shared stimulus and checked every cycle against a timestamp model.
module tb_omux_sync;

  logic        clk;
  logic        rst;
  logic [23:0] in_bus;
  logic [1:0]  sel_req;
  logic        sel_valid;

  logic [7:0]  a_out, b_out;
  logic [1:0]  a_cur, b_cur;
  logic        a_rdy, b_rdy, a_sw, b_sw, a_err, b_err;

  int errors = 0;
  int checks = 0;

  omux_sync #(.WIDTH(8), .NUM_INPUTS(3), .DEFAULT_SEL(1), .HOLD_CYCLES(2), .REGISTER_OUTPUT(1)) u_a (
    .clk(clk), .rst(rst), .in(in_bus), .sel_req(sel_req), .sel_valid(sel_valid),
    .sel_ready(a_rdy), .cur_sel(a_cur), .out(a_out), .switching(a_sw), .sel_err(a_err)
  );

  omux_sync #(.WIDTH(8), .NUM_INPUTS(3), .DEFAULT_SEL(0), .HOLD_CYCLES(3), .REGISTER_OUTPUT(0)) u_b (
    .clk(clk), .rst(rst), .in(in_bus), .sel_req(sel_req), .sel_valid(sel_valid),
    .sel_ready(b_rdy), .cur_sel(b_cur), .out(b_out), .switching(b_sw), .sel_err(b_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Model: a switch accepted at edge T ends at edge T+H; in between nothing moves.
  int   h_p   [2] = '{2, 3};
  int   def_p [2] = '{1, 0};
  int   rego_p[2] = '{1, 0};
  int   ecount = 0;
  bit   model_ok = 0;
  bit   m_busy [2];
  int   m_exit [2];
  int   m_pend [2];
  int   m_cur  [2];
  logic [7:0] m_hold [2];
  logic [7:0] m_outr [2];
  bit   m_err  [2];

  function automatic logic [7:0] chan_of(input logic [23:0] bus, input int k);
    return bus[k*8 +: 8];
  endfunction

  task automatic model_step();
    ecount++;
    if (rst) model_ok = 1;
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        m_busy[m] = 0; m_cur[m] = def_p[m]; m_hold[m] = 8'h00;
        m_outr[m] = 8'h00; m_err[m] = 0;
      end else if (m_busy[m]) begin
        m_err[m] = 0;
        if (ecount == m_exit[m]) begin
          m_cur[m]  = m_pend[m];
          m_busy[m] = 0;
        end
      end else begin
        m_hold[m] = chan_of(in_bus, m_cur[m]);
        m_outr[m] = m_hold[m];
        m_err[m]  = sel_valid && (int'(sel_req) >= 3);
        if (sel_valid && int'(sel_req) < 3 && int'(sel_req) != m_cur[m]) begin
          m_busy[m] = 1;
          m_exit[m] = ecount + h_p[m];
          m_pend[m] = int'(sel_req);
        end
      end
    end
  endtask

  function automatic logic [7:0] exp_out(input int m);
    if (rego_p[m] != 0) return m_outr[m];
    return m_busy[m] ? m_hold[m] : chan_of(in_bus, m_cur[m]);
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      if (model_ok) begin
        chk("a_out",       32'(a_out), 32'(exp_out(0)));
        chk("a_cur_sel",   32'(a_cur), 32'(m_cur[0]));
        chk("a_switching", 32'(a_sw),  32'(m_busy[0]));
        chk("a_sel_ready", 32'(a_rdy), 32'(!m_busy[0] && !rst));
        chk("a_sel_err",   32'(a_err), 32'(m_err[0]));
        chk("b_out",       32'(b_out), 32'(exp_out(1)));
        chk("b_cur_sel",   32'(b_cur), 32'(m_cur[1]));
        chk("b_switching", 32'(b_sw),  32'(m_busy[1]));
        chk("b_sel_ready", 32'(b_rdy), 32'(!m_busy[1] && !rst));
        chk("b_sel_err",   32'(b_err), 32'(m_err[1]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_bus = {8'h00, 8'hB2, 8'hA1}; sel_valid = 1'b0; sel_req = 2'd0;

    // Reset held two cycles, then release.
    tick();
    chk("rst_a_out",   32'(a_out), 32'h00);
    chk("rst_a_cur",   32'(a_cur), 32'd1);
    chk("rst_a_ready", 32'(a_rdy), 32'd0);
    chk("rst_a_sw",    32'(a_sw),  32'd0);
    tick();
    chk("rst_b_cur",   32'(b_cur), 32'd0);
    rst = 1'b0;
    tick();
    chk("rel_a_out",   32'(a_out), 32'hB2);
    chk("rel_a_ready", 32'(a_rdy), 32'd1);
    chk("rel_b_out",   32'(b_out), 32'hA1);

    // Move A to channel 0 (B already there: no-op).
    sel_req = 2'd0; sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    chk("b_noop_sw", 32'(b_sw), 32'd0);
    tick(); tick();
    chk("a_to0_cur", 32'(a_cur), 32'd0);
    tick();

    // Normal switch 0 -> 1; in0 changes after the accept edge.
    in_bus = {8'h00, 8'h55, 8'h11}; sel_req = 2'd1; sel_valid = 1'b1;
    tick();
    in_bus = {8'h00, 8'h55, 8'h22}; sel_valid = 1'b0;
    #1;
    chk("sw_a_out_t1",  32'(a_out), 32'h11);
    chk("sw_a_sw_t1",   32'(a_sw),  32'd1);
    chk("sw_a_rdy_t1",  32'(a_rdy), 32'd0);
    chk("sw_b_frozen",  32'(b_out), 32'h11);
    tick();
    chk("sw_a_out_t2",  32'(a_out), 32'h11);
    chk("sw_a_cur_t2",  32'(a_cur), 32'd0);
    tick();
    chk("sw_a_cur_t3",  32'(a_cur), 32'd1);
    chk("sw_a_rdy_t3",  32'(a_rdy), 32'd1);
    chk("sw_a_out_t3",  32'(a_out), 32'h11);
    chk("sw_b_sw_t3",   32'(b_sw),  32'd1);
    tick();
    chk("sw_a_out_t4",  32'(a_out), 32'h55);
    chk("sw_b_cur_t4",  32'(b_cur), 32'd1);
    chk("sw_b_out_t4",  32'(b_out), 32'h55);

    // Out-of-range request.
    sel_req = 2'd3; sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    chk("oor_a_err",  32'(a_err), 32'd1);
    chk("oor_b_err",  32'(b_err), 32'd1);
    chk("oor_a_sw",   32'(a_sw),  32'd0);
    chk("oor_a_cur",  32'(a_cur), 32'd1);
    tick();
    chk("oor_a_err2", 32'(a_err), 32'd0);

    // Same-channel request keeps tracking.
    sel_req = 2'd1; sel_valid = 1'b1;
    tick();
    chk("same_a_sw",  32'(a_sw),  32'd0);
    chk("same_a_rdy", 32'(a_rdy), 32'd1);
    in_bus = {8'h00, 8'h66, 8'h22}; sel_valid = 1'b0;
    #1;
    chk("same_b_out", 32'(b_out), 32'h66);
    tick();
    chk("same_a_out", 32'(a_out), 32'h66);

    // Switch to 2; a request during HOLD is ignored.
    sel_req = 2'd2; sel_valid = 1'b1;
    tick();
    sel_req = 2'd0;
    tick();
    sel_valid = 1'b0;
    tick();
    chk("hreq_a_cur", 32'(a_cur), 32'd2);
    tick();
    chk("hreq_a_sw",  32'(a_sw),  32'd0);
    chk("hreq_b_cur", 32'(b_cur), 32'd2);

    // Reset in the middle of HOLD.
    sel_req = 2'd0; sel_valid = 1'b1;
    tick();
    chk("mid_a_sw", 32'(a_sw), 32'd1);
    sel_valid = 1'b0; rst = 1'b1;
    tick();
    chk("mid_a_cur", 32'(a_cur), 32'd1);
    chk("mid_a_sw2", 32'(a_sw),  32'd0);
    chk("mid_a_out", 32'(a_out), 32'h00);
    chk("mid_b_cur", 32'(b_cur), 32'd0);
    chk("mid_b_sw",  32'(b_sw),  32'd0);
    rst = 1'b0;

    // Randomised traffic, checked by the model every cycle.
    repeat (3000) begin
      tick();
      rst       = ($urandom_range(0, 39) == 0);
      sel_valid = 1'($urandom_range(0, 1));
      sel_req   = 2'($urandom_range(0, 3));
      in_bus    = 24'($urandom);
    end
    rst = 1'b0; sel_valid = 1'b0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
